// File: rtl/core_pkg.sv
// core_pkg: shared types and widths for the core pipeline.
//   XLEN     datapath width (32 only)
//   RADDR    register address width
//   alu_op_e 4-bit ALU operation encoding
package core_pkg;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_XNOR = 4'hA
    } alu_op_e;

    // Shift ops take only the low five bits of src2 as the amount.
    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational 32-bit ALU used by ex_stage.
// Ports:
//   op     in  alu_op_e  operation
//   a      in  XLEN      operand 1
//   b      in  XLEN      operand 2 (shift amount already masked by the caller)
//   result out XLEN      result; unused encodings give 0
module alu
    import core_pkg::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XNOR: result = ~(a ^ b);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage. Accepts one decoded op per handshake, selects and
// forwards operands, runs the ALU and registers the result into the EX/MEM
// register (valid/ready towards the memory stage). Latency 1, throughput 1.
// Build option: define EX_FWD_EN to enable operand forwarding from the EX/MEM
// register (priority 1) and the writeback port (priority 2). Without it the
// register-file values are used raw and the wb_* ports are ignored.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   flush                           drop the incoming op and kill the held one
//   in_valid / in_ready             decode handshake
//   in_alu_op, in_rs*_addr/data     op and source operands
//   in_pc, in_imm, in_src1_pc,
//   in_src2_imm                     alternate operand sources
//   in_rd_addr, in_rd_we            destination
//   wb_rd_we, wb_rd_addr, wb_data   writeback forwarding source
//   out_valid / out_ready           memory-stage handshake
//   out_result, out_store_data,
//   out_rd_addr, out_rd_we          registered EX/MEM contents
module ex_stage
    import core_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_op,
    input  logic [RADDR-1:0] in_rs1_addr,
    input  logic [RADDR-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_src1_pc,
    input  logic             in_src2_imm,
    input  logic [RADDR-1:0] in_rd_addr,
    input  logic             in_rd_we,
    input  logic             wb_rd_we,
    input  logic [RADDR-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_store_data,
    output logic [RADDR-1:0] out_rd_addr,
    output logic             out_rd_we
);

    alu_op_e         op;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] src2_alu;
    logic [XLEN-1:0] alu_result;

    assign op       = alu_op_e'(in_alu_op);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef EX_FWD_EN
    // The held EX/MEM op is younger than the writeback op, so it wins.
    always_comb begin
        rs1_val = in_rs1_data;
        rs2_val = in_rs2_data;
        if (in_rs1_addr != '0) begin
            if (out_valid && out_rd_we && (out_rd_addr == in_rs1_addr))
                rs1_val = out_result;
            else if (wb_rd_we && (wb_rd_addr == in_rs1_addr))
                rs1_val = wb_data;
        end
        if (in_rs2_addr != '0) begin
            if (out_valid && out_rd_we && (out_rd_addr == in_rs2_addr))
                rs2_val = out_result;
            else if (wb_rd_we && (wb_rd_addr == in_rs2_addr))
                rs2_val = wb_data;
        end
    end
`else
    // Decode stalls on hazards in this build; the forwarding inputs are dead.
    logic unused_fwd;
    assign unused_fwd = &{1'b0, wb_rd_we, wb_rd_addr, wb_data, in_rs1_addr, in_rs2_addr};
    assign rs1_val = in_rs1_data;
    assign rs2_val = in_rs2_data;
`endif

    assign src1     = in_src1_pc  ? in_pc  : rs1_val;
    assign src2     = in_src2_imm ? in_imm : rs2_val;
    assign src2_alu = is_shift(op) ? {{(XLEN-5){1'b0}}, src2[4:0]} : src2;

    alu u_alu (
        .op     (op),
        .a      (src1),
        .b      (src2_alu),
        .result (alu_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset as well, so the memory stage never sees X after reset.
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd_addr    <= '0;
            out_rd_we      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_result     <= alu_result;
            out_store_data <= rs2_val;
            out_rd_addr    <= in_rd_addr;
            out_rd_we      <= in_rd_we && (in_rd_addr != '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and randomized checks of ex_stage against a behavioural
// model of the EX/MEM register contents. Build option EX_FWD_EN selects whether
// the model forwards operands.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
    logic        in_src1_pc, in_src2_imm, in_rd_we;
    logic        wb_rd_we;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;

    int n_vec = 0;
    int n_err = 0;

    // Model of the EX/MEM register.
    logic        m_valid;
    logic [31:0] m_result, m_store;
    logic [4:0]  m_rd;
    logic        m_we;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_pc(in_pc), .in_imm(in_imm), .in_src1_pc(in_src1_pc), .in_src2_imm(in_src2_imm),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return ~(a ^ b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return rf;
`ifdef EX_FWD_EN
        if (m_valid && m_we && m_rd == a) return m_result;
        if (wb_rd_we && wb_rd_addr == a) return wb_data;
`endif
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_result = '0; m_store = '0; m_rd = '0; m_we = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"},  {31'd0, out_valid}, {31'd0, m_valid});
        check({tag, ".result"}, out_result, m_result);
        check({tag, ".store"},  out_store_data, m_store);
        check({tag, ".rd"},     {27'd0, out_rd_addr}, {27'd0, m_rd});
        check({tag, ".we"},     {31'd0, out_rd_we}, {31'd0, m_we});
    endtask

    // Called just after a rising edge with inputs already driven. Checks the
    // handshake, advances one cycle, then checks the EX/MEM contents.
    task automatic step(input string tag);
        logic        acc;
        logic [31:0] a, b, rs2v, res;
        #1;
        check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        acc  = in_valid && (!m_valid || out_ready) && !flush;
        rs2v = ref_src(in_rs2_addr, in_rs2_data);
        a    = in_src1_pc  ? in_pc  : ref_src(in_rs1_addr, in_rs1_data);
        b    = in_src2_imm ? in_imm : rs2v;
        res  = ref_alu(in_alu_op, a, b);
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1; m_result = res; m_store = rs2v;
            m_rd = in_rd_addr; m_we = in_rd_we && (in_rd_addr != 5'd0);
        end else if (out_ready) m_valid = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    task automatic set_op(input logic [3:0] op, input logic [4:0] r1a, input logic [31:0] r1d,
                          input logic [4:0] r2a, input logic [31:0] r2d, input logic s2imm,
                          input logic [31:0] imm, input logic [4:0] rd);
        in_valid = 1'b1; in_alu_op = op;
        in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a; in_rs2_data = r2d;
        in_src1_pc = 1'b0; in_pc = 32'h0000_1000; in_src2_imm = s2imm; in_imm = imm;
        in_rd_addr = rd; in_rd_we = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_alu_op = '0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
        in_rs1_data = '0; in_rs2_data = '0; in_pc = '0; in_imm = '0;
        in_src1_pc = 1'b0; in_src2_imm = 1'b0; in_rd_we = 1'b0;
        wb_rd_we = 1'b0; wb_rd_addr = '0; wb_data = '0;
        model_reset();
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with immediate: 5 + (-3)
        set_op(4'd0, 5'd1, 32'd5, 5'd0, 32'd0, 1'b1, 32'hFFFF_FFFD, 5'd4);
        step("add_imm");
        check("add_imm.const", out_result, 32'd2);

        // Back-to-back dependency through EX/MEM.
        set_op(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'd7, 5'd1);
        step("fwd_a");
        set_op(4'd0, 5'd1, 32'd0, 5'd1, 32'd0, 1'b0, 32'd0, 5'd2);
        step("fwd_b");
`ifdef EX_FWD_EN
        check("fwd_b.const", out_result, 32'd14);
`else
        check("fwd_b.const", out_result, 32'd0);
`endif

        // EX/MEM beats WB.
        set_op(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 32'd1, 5'd3);
        step("prio_a");
        set_op(4'd0, 5'd3, 32'd0, 5'd0, 32'd0, 1'b1, 32'd0, 5'd5);
        wb_rd_we = 1'b1; wb_rd_addr = 5'd3; wb_data = 32'd9;
        step("prio_b");
`ifdef EX_FWD_EN
        check("prio_b.const", out_result, 32'd1);
`else
        check("prio_b.const", out_result, 32'd0);
`endif

        // rd=x0: write enable is dropped, and x0 never forwards.
        set_op(4'd0, 5'd0, 32'h10, 5'd0, 32'd0, 1'b1, 32'd5, 5'd0);
        wb_rd_addr = 5'd0; wb_data = 32'd99;
        step("x0_we");
        check("x0_we.const", {31'd0, out_rd_we}, 32'd0);
        set_op(4'd0, 5'd0, 32'h20, 5'd0, 32'd0, 1'b1, 32'd0, 5'd6);
        step("x0_nofwd");
        check("x0_nofwd.const", out_result, 32'h20);
        wb_rd_we = 1'b0;

        // Backpressure for three cycles, then release with a stream.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(4'd2 + 4'(i), 5'd7, 32'h0F0F_0000 + i, 5'd8, 32'h00FF_00FF, 1'b0, 32'd0, 5'd9);
            step("bp_hold");
            check("bp_hold.in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(4'd1, 5'd10, 32'd100 + i, 5'd11, 32'd1, 1'b0, 32'd0, 5'd12);
            step("bp_release");
        end

        // SRA by 33 uses amount 1.
        set_op(4'd7, 5'd13, 32'h8000_0000, 5'd0, 32'd0, 1'b1, 32'd33, 5'd14);
        step("sra");
        check("sra.const", out_result, 32'hC000_0000);

        // Flush drops the incoming op and clears out_valid.
        set_op(4'd0, 5'd0, 32'd55, 5'd0, 32'd0, 1'b1, 32'd1, 5'd15);
        flush = 1'b1;
        step("flush");
        check("flush.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;

        // Asynchronous reset while an op is held under backpressure.
        out_ready = 1'b0;
        set_op(4'd3, 5'd0, 32'h1234, 5'd0, 32'd0, 1'b1, 32'h1, 5'd16);
        step("pre_reset");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with frequent register overlap.
        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_alu_op   = 4'($urandom_range(0, 15));
            in_rs1_addr = 5'($urandom_range(0, 3));
            in_rs2_addr = 5'($urandom_range(0, 3));
            in_rd_addr  = 5'($urandom_range(0, 3));
            in_rd_we    = 1'($urandom_range(0, 1));
            in_rs1_data = $urandom();
            in_rs2_data = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 70));
            in_pc       = $urandom();
            in_imm      = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 70));
            in_src1_pc  = ($urandom_range(0, 3) == 0);
            in_src2_imm = 1'($urandom_range(0, 1));
            wb_rd_we    = 1'($urandom_range(0, 1));
            wb_rd_addr  = 5'($urandom_range(0, 3));
            wb_data     = $urandom();
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
